// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants and state encoding for the multi-pass right shifter
package shift_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 5;
  localparam int STEP_W = 3;

  localparam logic [STEP_W-1:0] STEP_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest pass that still fits in the remaining amount.
  function automatic logic [STEP_W-1:0] pass_step(input logic [AMT_W-1:0] rem);
    if (rem > AMT_W'(STEP_MAX)) begin
      return STEP_MAX;
    end
    return rem[STEP_W-1:0];
  endfunction

endpackage

// File: rtl/shifter8bit_right.sv
// rtl/shifter8bit_right.sv - combinational 8-bit logical right barrel shifter, 0..7 positions
module shifter8bit_right (
  input  logic [2:0] s,
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] stage1;
  logic [7:0] stage2;

  assign stage1 = s[0] ? {1'b0, a[7:1]}      : a;
  assign stage2 = s[1] ? {2'b00, stage1[7:2]} : stage1;
  assign y      = s[2] ? {4'h0, stage2[7:4]}  : stage2;

endmodule

// File: rtl/shift_iter8b_r.sv
// rtl/shift_iter8b_r.sv - splits 0..31 position right shifts into passes of at most 7 through one shifter
module shift_iter8b_r
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic                live_q;
  logic [STEP_W-1:0]   step;
  logic [DATA_W-1:0]   shift_y;

  assign step = pass_step(rem_q);

  shifter8bit_right u_shifter (
    .s (step),
    .a (data_q),
    .y (shift_y)
  );

  // live_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          rem_d   = in_amt;
          state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = shift_y;
        rem_d  = rem_q - AMT_W'(step);
        if (rem_q <= AMT_W'(STEP_MAX)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = live_q && (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    out_data  = data_q;
  end

endmodule

// File: tb/tb_shift_iter8b_r.sv
// tb/tb_shift_iter8b_r.sv - directed self-checking bench for shift_iter8b_r
module tb_shift_iter8b_r;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int tests;
  int fails;

  shift_iter8b_r dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // Accept one request and return the cycle index at which out_valid first appears.
  task automatic send(input logic [7:0] d, input logic [4:0] a, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step_cycle();
      guard++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    step_cycle();
    in_valid = 1'b0;
    in_data  = 8'h5A;
    in_amt   = 5'd17;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step_cycle();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step_cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b data=%h expected 0 0 0 00",
               in_ready, out_valid, busy, out_data);
    end
    step_cycle();
    step_cycle();
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_held: got %b expected 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step_cycle();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_amt3();
    int lat;
    send(8'h18, 5'd3, lat);
    tests++;
    if (lat !== 2 || out_data !== 8'h03) begin
      fails++;
      $display("FAIL amt3: lat=%0d data=%h expected lat=2 data=03", lat, out_data);
    end
    consume();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL amt3_return: rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_amt0();
    int lat;
    send(8'h18, 5'd0, lat);
    tests++;
    if (lat !== 1 || out_data !== 8'h18 || busy !== 1'b1) begin
      fails++;
      $display("FAIL amt0: lat=%0d data=%h busy=%b expected lat=1 data=18 busy=1", lat, out_data, busy);
    end
    consume();
  endtask

  task automatic test_multi_pass();
    int lat;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    in_amt   = 5'd9;
    step_cycle();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    in_amt   = 5'd1;
    step_cycle();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h01) begin
      fails++;
      $display("FAIL amt9_pass1: vld=%b data=%h expected 0 01", out_valid, out_data);
    end
    step_cycle();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL amt9_final: vld=%b data=%h expected 1 00", out_valid, out_data);
    end
    consume();
    send(8'h80, 5'd7, lat);
    tests++;
    if (lat !== 2 || out_data !== 8'h01) begin
      fails++;
      $display("FAIL amt7: lat=%0d data=%h expected lat=2 data=01", lat, out_data);
    end
    consume();
    send(8'hB6, 5'd8, lat);
    tests++;
    if (lat !== 3 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL amt8: lat=%0d data=%h expected lat=3 data=00", lat, out_data);
    end
    consume();
  endtask

  task automatic test_hold_max();
    int lat;
    send(8'hFF, 5'd31, lat);
    tests++;
    if (lat !== 6 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL amt31: lat=%0d data=%h expected lat=6 data=00", lat, out_data);
    end
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_amt   = 5'd1;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d: vld=%b data=%h rdy=%b expected 1 00 0", i, out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step_cycle();
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL ignored_req_%0d: vld=%b busy=%b expected 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         b_acc;
    int         nres;
    logic [7:0] res [2];
    b_acc     = -1;
    nres      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h18;
    in_amt    = 5'd1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && nres < 2) begin
        res[nres] = out_data;
        nres++;
      end
      if (c > 0 && in_valid && in_ready) b_acc = c;
      step_cycle();
      if (c == 0) begin
        in_data = 8'hC0;
        in_amt  = 5'd6;
      end
      if (b_acc >= 0) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    tests++;
    if (b_acc !== 3) begin
      fails++;
      $display("FAIL b2b_accept_cycle: got %0d expected 3", b_acc);
    end
    tests++;
    if (nres !== 2 || res[0] !== 8'h0C || res[1] !== 8'h03) begin
      fails++;
      $display("FAIL b2b_results: n=%0d a=%h b=%h expected n=2 a=0c b=03", nres, res[0], res[1]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_amt   = 5'd31;
    step_cycle();
    in_valid = 1'b0;
    step_cycle();
    step_cycle();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_shift_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_shift_reset: vld=%b busy=%b data=%h rdy=%b expected 0 0 00 0",
               out_valid, busy, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step_cycle();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_shift_release_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      step_cycle();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL stale_result_%0d: vld=%b expected 0", i, out_valid);
      end
    end
    send(8'h18, 5'd0, lat);
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_data !== 8'h00 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_reset: data=%h vld=%b expected 00 0", out_data, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step_cycle();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 5'd0;
    out_ready = 1'b0;
    test_reset();
    test_amt3();
    test_amt0();
    test_multi_pass();
    test_hold_max();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_iter8b_r.md
# shift_iter8b_r

Multi-cycle right-shift sequencer that sits directly upstream of the combinational 8-bit right barrel shifter `shifter8bit_right` and drives its `s`/`a` inputs. The combinational shifter moves at most 7 positions. This block accepts shift requests of 0..31 positions over a valid/ready handshake. It decomposes each request into successive passes of at most 7 positions through one shifter instance, registers the partial result between passes, and presents the final word on a valid/ready output.

## Interface
- `DATA_W`, 8: data width. Fixed at 8 to match the shifter.
- `AMT_W`, 5: request shift-amount width. The maximum request is 31.
- `STEP_MAX`, 7: largest per-pass shift. It equals the shifter's 3-bit `s` range.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: block can accept a request.
- `in_data`  in  8: word to shift.
- `in_amt`  in  5: total logical right-shift amount.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  8: shifted result. Logical shift, zero fill.
- `busy`  out  1: request in flight (state SHIFT or DONE).

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`, capture `data_r`<=`in_data` and `rem_r`<=`in_amt`. Go to DONE if `in_amt`==0, else go to SHIFT.
  - SHIFT: compute `step` = min(`rem_r`, 7) and drive shifter `s`=`step`, `a`=`data_r`. Each edge: `data_r`<=`y`, `rem_r`<=`rem_r`-`step`. When `rem_r`<=7, go to DONE.
  - DONE: `out_valid`=1 and `out_data`=`data_r`. On `out_ready`, go to IDLE.
- No early termination when `data_r` becomes 0. The pass count depends only on `in_amt`.
- `rem_r` is 5 bits. The subtraction never underflows because `step`<=`rem_r`.
- `in_valid` in SHIFT or DONE is ignored. `in_ready`=0 there, and no request is buffered.
- No same-cycle accept in DONE. A new request is accepted only in IDLE.
- Input fields are sampled only on the accept edge. Later changes to `in_data`/`in_amt` have no effect.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Cycle 0 is the accept cycle. P = ceil(`in_amt`/7), so P is 0..5.
  - `in_amt`=0: `out_valid` is high from cycle 1.
  - `in_amt`>0: SHIFT occupies cycles 1..P. `out_valid` is high from cycle P+1.
  - `in_amt`=31 uses passes 7,7,7,7,3 and gives `out_valid` at cycle 6.
- The earliest next accept is cycle P+2, when `out_ready` is high in cycle P+1.
- `in_ready`, `out_valid`, and `busy` decode from registered state only, with no combinational path from inputs.
- Reset (`rst_n` low, asynchronous):
  - State goes to IDLE, and `data_r`, `rem_r`, and `out_data` go to 0.
  - `out_valid`=0 and `busy`=0.
  - `in_ready`=0 while `rst_n` is low, and 1 from the first cycle after release.
- Reset mid-SHIFT or mid-DONE abandons the request. No output is produced for it.

## Structure
- Shared package/include `shift_pkg`:
  - Constants `DATA_W`, `AMT_W`, `STEP_MAX`.
  - State encoding `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2.
- One sub-module: an existing `shifter8bit_right` instance (`s`, `a`, `y`) fed from `data_r` and `step`. No second shifter and no inline shift operator.
- Unused state encoding 2'd3 recovers to IDLE.

## Test plan
- Accept `in_data`=0x18, `in_amt`=3 -> one SHIFT cycle, `out_valid` at cycle 2, `out_data`=0x03.
- Accept 0x18, `in_amt`=0 -> `out_valid` at cycle 1, `out_data`=0x18, shifter never stepped.
- Accept 0xF0, `in_amt`=9 -> passes 7 then 2 (0x01 then 0x00), `out_valid` at cycle 3, `out_data`=0x00. Also accept 0x80, `in_amt`=7 -> 0x01 at cycle 2.
- Accept 0xFF, `in_amt`=31 -> five passes, `out_valid` at cycle 6, `out_data`=0x00. Hold `out_ready` low 5 cycles -> `out_data` stable, `in_ready`=0, and a new `in_valid` is ignored. Raise `out_ready` -> `in_ready`=1 next cycle.
- Back-to-back: request A (0x18, 1) with `out_ready` tied high, then `in_valid` held with B (0xC0, 6) -> B accepted cycle 3, A result 0x0C, B result 0x03.
- Assert `rst_n` low during the third SHIFT pass of an `in_amt`=31 request -> `out_valid`/`busy`/`out_data` go to 0 immediately. After release: `in_ready`=1, and no stale result appears.
